// File: rtl/fetch_pkg.sv
// Shared widths, step constant and FIFO entry type for the fetch stage.
// Latency: none (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    // One fetched instruction together with the byte address it came from.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode bundle: instruction handshake plus the redirect request coming back.
// Latency: none (wires only).
// Backpressure: out_ready from decode holds the head; redirect is a one-cycle pulse.
// Ports: master = fetch side (drives out_*), slave = decode side (drives out_ready, redir_*).
interface fetch_if;
    import fetch_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [PC_W-1:0]    out_pc4;
    logic               redir_valid;
    logic [PC_W-1:0]    redir_pc;

    modport master (
        output out_valid, out_instr, out_pc, out_pc4,
        input  out_ready, redir_valid, redir_pc
    );

    modport slave (
        input  out_valid, out_instr, out_pc, out_pc4,
        output out_ready, redir_valid, redir_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetch entries with push, pop, flush and occupancy count.
// Latency: a pushed entry is visible at the head one cycle later.
// Backpressure: none internally; the caller must not push when full without a pop.
// Ports: clk, reset_n, push/din, pop, flush (wins over push), head, count (0..2).
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;

    // When full with a simultaneous push and pop, wr_ptr equals rd_ptr: the
    // outgoing head slot is reused for the new tail, which is exactly right.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads combinational imem, buffers 2 entries for decode.
// Latency: fetch issues the cycle after reset release/redirect; output valid one cycle later.
// Backpressure: out_ready low fills the 2-entry buffer, then fetch stalls with pc = head_pc + 8.
// Ports: clk, reset_n (async, active low), imem_a/imem_rd, fif (fetch_if.master), fetch_misalign.
// Option: FETCH_ALIGN_CHECK_EN halts fetch on a misaligned redirect until an aligned one.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int              IMEM_AW  = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic [IMEM_AW-1:0]  imem_a,
    input  logic [INSTR_W-1:0]  imem_rd,
    fetch_if.master             fif,
    output logic                fetch_misalign
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] redir_tgt;
    logic [1:0]      count;
    logic            pop;
    logic            issue;
    logic            halt;
    fetch_entry_t    head;
    fetch_entry_t    push_dat;

`ifdef FETCH_ALIGN_CHECK_EN
    logic redir_misaligned;

    assign redir_misaligned = (fif.redir_pc[1:0] != 2'b00);
    assign redir_tgt        = fif.redir_pc;

    // Every redirect re-evaluates the flag, so an aligned one clears a halt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            halt           <= 1'b0;
            fetch_misalign <= 1'b0;
        end else if (fif.redir_valid) begin
            halt           <= redir_misaligned;
            fetch_misalign <= redir_misaligned;
        end
    end
`else
    assign redir_tgt      = fif.redir_pc & ~32'h0000_0003;
    assign halt           = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

    // out_valid depends only on registered count; out_ready feeds next-state only.
    assign fif.out_valid = (count != 2'd0);
    assign pop           = fif.out_valid && fif.out_ready;
    assign issue         = !fif.redir_valid && !halt && ((count != 2'd2) || pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (fif.redir_valid) begin
            pc <= redir_tgt;
        end else if (issue) begin
            pc <= pc + PC_STEP;
        end
    end

    assign imem_a         = pc[IMEM_AW+1:2];
    assign push_dat.pc    = pc;
    assign push_dat.instr = imem_rd;

    fetch_fifo u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (issue),
        .din     (push_dat),
        .pop     (pop),
        .flush   (fif.redir_valid),
        .head    (head),
        .count   (count)
    );

    assign fif.out_instr = head.instr;
    assign fif.out_pc    = head.pc;
    // Forced to zero while empty so the idle/reset value is 0 rather than 4.
    assign fif.out_pc4   = fif.out_valid ? (head.pc + PC_STEP) : '0;

endmodule
